// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {RD_NONE, RD_BRANCH, RD_CSR} redirect_src_e;
endpackage

// File: rtl/fetch_buffer.sv
// Fetch buffer: small circular FIFO of {pc, inst} entries with a synchronous clear.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  fetch_entry_t din,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full buffer still accepts a write when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order imem requests, buffers responses for IF/ID.
// Optional FETCH_MISALIGN_EN adds a sticky fetch_misaligned flag for unaligned redirect targets.
module pc_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Stall,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        csr_redirect,
  input  logic [31:0] csr_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Addr,
  output logic [31:0] Inst,
  output logic        inst_valid
`ifdef FETCH_MISALIGN_EN
  ,
  output logic        fetch_misaligned
`endif
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [31:0]   aq [FIFO_DEPTH];
  logic [AW-1:0] aq_wr;
  logic [AW-1:0] aq_rd;

  redirect_src_e rd_src;
  logic          redirect;
  logic [31:0]   rd_target;
  logic [31:0]   next_pc_target;
  logic          fire;
  logic          rsp_live;
  logic          rsp_keep;
  logic          fetch_block;
  logic [CW:0]   inflight;

  fetch_entry_t  buf_din;
  fetch_entry_t  buf_head;
  logic [CW-1:0] buf_count;
  logic          buf_full;
  logic          buf_empty;

  always_comb begin
    rd_src    = RD_NONE;
    rd_target = pc;
    if (csr_redirect) begin
      rd_src    = RD_CSR;
      rd_target = csr_pc;
    end else if (br_taken) begin
      rd_src    = RD_BRANCH;
      rd_target = br_target;
    end
  end

  assign redirect = (rd_src != RD_NONE);

`ifdef FETCH_MISALIGN_EN
  assign next_pc_target = rd_target;
  assign fetch_block    = fetch_misaligned;
`else
  assign next_pc_target = rd_target & 32'hFFFF_FFFC;
  assign fetch_block    = 1'b0;
`endif

  // Responses only count while something is outstanding, so stale beats after reset vanish.
  assign rsp_live = imem_rvalid && (outstanding != '0);
  assign rsp_keep = rsp_live && (drop == '0) && !redirect;
  assign inflight = {1'b0, outstanding} + {1'b0, buf_count};
  assign imem_req = rst && (inflight < (CW+1)'(FIFO_DEPTH)) && !redirect && !fetch_block;
  assign imem_addr = pc;
  assign fire     = imem_req && imem_gnt;

  // ---- request stage: PC and in-flight bookkeeping ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      aq_wr       <= '0;
      aq_rd       <= '0;
    end else begin
      outstanding <= outstanding + CW'(fire) - CW'(rsp_live);
      if (fire)     aq_wr <= aq_wr + AW'(1);
      if (rsp_live) aq_rd <= aq_rd + AW'(1);
      if (redirect) begin
        pc   <= next_pc_target;
        drop <= outstanding - CW'(rsp_live);
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (rsp_live && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) aq[aq_wr] <= pc;
  end

`ifdef FETCH_MISALIGN_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          fetch_misaligned <= 1'b0;
    else if (redirect) fetch_misaligned <= (rd_target[1:0] != 2'b00);
  end
`endif

  // ---- response stage: buffer toward IF/ID ----
  assign buf_din.pc   = aq[aq_rd];
  assign buf_din.inst = imem_rdata;

  fetch_buffer #(
    .DEPTH (FIFO_DEPTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (rsp_keep),
    .pop   (!Stall),
    .clear (redirect),
    .din   (buf_din),
    .head  (buf_head),
    .count (buf_count),
    .full  (buf_full),
    .empty (buf_empty)
  );

  assign inst_valid = !buf_empty;
  assign Addr       = buf_empty ? 32'h0 : buf_head.pc;
  assign Inst       = buf_empty ? NOP_INST : buf_head.inst;

  assert property (@(posedge clk) disable iff (!rst) !(rsp_live && buf_full));
endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: imem responder model plus an in-order PC scoreboard.
module tb_pc_fetch_unit;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        Stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        csr_redirect = 1'b0;
  logic [31:0] csr_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] Addr;
  logic [31:0] Inst;
  logic        inst_valid;
`ifdef FETCH_MISALIGN_EN
  logic        fetch_misaligned;
`endif

  pc_fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .Stall(Stall),
    .br_taken(br_taken), .br_target(br_target),
    .csr_redirect(csr_redirect), .csr_pc(csr_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .Addr(Addr), .Inst(Inst), .inst_valid(inst_valid)
`ifdef FETCH_MISALIGN_EN
    , .fetch_misaligned(fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // imem model: granted addresses awaiting their in-order response
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          cyc = 0;
  bit          hold_rsp = 0;
  bit          force_stale = 0;
  int          gnt_mode = 0;
  int          rsp_pct = 100;
  int          lat_extra = 0;

  // scoreboard: next PC that IF/ID must see
  logic [31:0] exp_pc = 32'h0;
  int          n_cons = 0;

  logic        obs_req, obs_valid, obs_mis;
  logic [31:0] obs_iaddr, obs_addr, obs_inst;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A3C_96E1;
  endfunction

  task automatic cycle(input bit br, input logic [31:0] bt, input bit csr,
                       input logic [31:0] ct, input bit stall);
    logic        fire;
    logic [31:0] faddr;
    logic [31:0] tgt;
    bit          redir;
    @(negedge clk);
    br_taken = br; br_target = bt; csr_redirect = csr; csr_pc = ct; Stall = stall;
    if (force_stale) begin
      imem_rvalid = 1'b1; imem_rdata = $urandom;
    end else if (!hold_rsp && pend_addr.size() != 0 && pend_due[0] <= cyc &&
                 $urandom_range(0, 99) < rsp_pct) begin
      imem_rvalid = 1'b1; imem_rdata = memf(pend_addr[0]);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    case (gnt_mode)
      0:       imem_gnt = 1'b1;
      1:       imem_gnt = 1'($urandom_range(0, 1));
      default: imem_gnt = 1'b0;
    endcase
    #1;
    obs_req = imem_req; obs_iaddr = imem_addr;
    obs_valid = inst_valid; obs_addr = Addr; obs_inst = Inst;
`ifdef FETCH_MISALIGN_EN
    obs_mis = fetch_misaligned;
`else
    obs_mis = 1'b0;
`endif
    redir = br || csr;
    if (redir) begin
      checks++;
      if (imem_req !== 1'b0) begin
        errors++; $display("FAIL redirect_req got %b want 0", imem_req);
      end
    end
    if (inst_valid === 1'b1 && !stall && !redir) begin
      checks++;
      if (Addr !== exp_pc || Inst !== memf(exp_pc)) begin
        errors++;
        $display("FAIL stream got addr=%h inst=%h want addr=%h inst=%h",
                 Addr, Inst, exp_pc, memf(exp_pc));
      end
      exp_pc = exp_pc + 32'd4;
      n_cons++;
    end
    fire = imem_req && imem_gnt;
    faddr = imem_addr;
    @(posedge clk);
    if (imem_rvalid && !force_stale && pend_addr.size() != 0) begin
      void'(pend_addr.pop_front()); void'(pend_due.pop_front());
    end
    if (fire === 1'b1) begin
      pend_addr.push_back(faddr);
      pend_due.push_back(cyc + 1 + $urandom_range(0, lat_extra));
    end
    if (redir) begin
      tgt = csr ? ct : bt;
`ifdef FETCH_MISALIGN_EN
      exp_pc = tgt;
`else
      exp_pc = tgt & 32'hFFFF_FFFC;
`endif
    end
    cyc++;
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst = 1'b0; br_taken = 0; csr_redirect = 0; Stall = 0; imem_gnt = 0; imem_rvalid = 0;
    #1;
    if (chk) begin
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b0 || Addr !== 32'h0 || Inst !== NOP) begin
        errors++;
        $display("FAIL reset_state got req=%b valid=%b addr=%h inst=%h want 0 0 0 %h",
                 imem_req, inst_valid, Addr, Inst, NOP);
      end
    end
    @(posedge clk);
    @(negedge clk);
    pend_addr.delete(); pend_due.delete();
    exp_pc = 32'h0; hold_rsp = 0; force_stale = 0;
    gnt_mode = 0; rsp_pct = 100; lat_extra = 0;
    rst = 1'b1;
  endtask

  task automatic drain();
    gnt_mode = 2;
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 0);
    gnt_mode = 0;
  endtask

  task automatic test_reset();
    do_reset(1);
    gnt_mode = 2;
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_req !== 1'b1 || obs_iaddr !== 32'h0) begin
      errors++; $display("FAIL reset_first_req got req=%b addr=%h want 1 00000000", obs_req, obs_iaddr);
    end
  endtask

  task automatic test_stream();
    int n0;
    do_reset(0);
    n0 = n_cons;
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0, 0);
    checks++;
    if (n_cons - n0 < 5) begin
      errors++; $display("FAIL stream_progress got %0d want >=5", n_cons - n0);
    end
  endtask

  task automatic test_stall();
    bit have = 0;
    logic [31:0] ra, ri;
    int n0;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 0, 0, 0, 1);
      if (obs_valid === 1'b1) begin
        if (!have) begin
          have = 1; ra = obs_addr; ri = obs_inst;
        end else begin
          checks++;
          if (obs_addr !== ra || obs_inst !== ri) begin
            errors++; $display("FAIL stall_hold got %h/%h want %h/%h", obs_addr, obs_inst, ra, ri);
          end
        end
      end
    end
    checks++;
    if (obs_req !== 1'b0 || obs_valid !== 1'b1) begin
      errors++; $display("FAIL stall_full got req=%b valid=%b want 0 1", obs_req, obs_valid);
    end
    n0 = n_cons;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
    checks++;
    if (n_cons - n0 < 4) begin
      errors++; $display("FAIL stall_release got %0d want >=4", n_cons - n0);
    end
  endtask

  task automatic test_branch();
    bit found = 0;
    do_reset(0);
    hold_rsp = 1;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_req !== 1'b0) begin
      errors++; $display("FAIL outstanding_limit got req=%b want 0", obs_req);
    end
    cycle(1, 32'h100, 0, 0, 0);
    hold_rsp = 0;
    for (int i = 0; i < 2; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (obs_valid !== 1'b0) begin
        errors++; $display("FAIL branch_drop got valid=%b addr=%h want 0", obs_valid, obs_addr);
      end
    end
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0);
      if (!found && obs_valid === 1'b1) begin
        found = 1;
        checks++;
        if (obs_addr !== 32'h100) begin
          errors++; $display("FAIL branch_first got %h want 00000100", obs_addr);
        end
      end
    end
    if (!found) begin
      checks++; errors++; $display("FAIL branch_first got no valid entry want 00000100");
    end
  endtask

  task automatic test_priority();
    int n0;
    drain();
    cycle(1, 32'h200, 1, 32'h80, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_req !== 1'b1 || obs_iaddr !== 32'h80) begin
      errors++; $display("FAIL csr_priority got req=%b addr=%h want 1 00000080", obs_req, obs_iaddr);
    end
    n0 = n_cons;
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);
    checks++;
    if (n_cons - n0 < 3) begin
      errors++; $display("FAIL csr_resume got %0d want >=3", n_cons - n0);
    end
  endtask

  task automatic test_gnt_low();
    do_reset(0);
    gnt_mode = 2;
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (obs_req !== 1'b1 || obs_iaddr !== 32'h0 || obs_valid !== 1'b0 || obs_inst !== NOP) begin
        errors++;
        $display("FAIL gnt_low got req=%b addr=%h valid=%b inst=%h want 1 00000000 0 %h",
                 obs_req, obs_iaddr, obs_valid, obs_inst, NOP);
      end
    end
    gnt_mode = 0;
    cycle(0, 0, 0, 0, 0);
    gnt_mode = 2;
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL latency_early got valid=%b want 0", obs_valid);
    end
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_valid !== 1'b1 || obs_addr !== 32'h0) begin
      errors++; $display("FAIL latency_n2 got valid=%b addr=%h want 1 00000000", obs_valid, obs_addr);
    end
    gnt_mode = 0;
  endtask

  task automatic test_reset_mid();
    int n0;
    hold_rsp = 1;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    do_reset(1);
    gnt_mode = 2; force_stale = 1;
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    force_stale = 0;
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_valid !== 1'b0) begin
      errors++; $display("FAIL stale_after_reset got valid=%b want 0", obs_valid);
    end
    gnt_mode = 0;
    n0 = n_cons;
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
    checks++;
    if (n_cons - n0 < 4) begin
      errors++; $display("FAIL reset_resume got %0d want >=4", n_cons - n0);
    end
  endtask

  task automatic test_wrap_align();
    int n0;
    drain();
    n0 = n_cons;
    cycle(1, 32'hFFFF_FFF8, 0, 0, 0);
    for (int i = 0; i < 12; i++) cycle(0, 0, 0, 0, 0);
    checks++;
    if (n_cons - n0 < 4) begin
      errors++; $display("FAIL pc_wrap got %0d want >=4", n_cons - n0);
    end
`ifndef FETCH_MISALIGN_EN
    drain();
    cycle(1, 32'h102, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_req !== 1'b1 || obs_iaddr !== 32'h100) begin
      errors++; $display("FAIL align_force got req=%b addr=%h want 1 00000100", obs_req, obs_iaddr);
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);
`endif
  endtask

`ifdef FETCH_MISALIGN_EN
  task automatic test_misalign();
    drain();
    cycle(1, 32'h102, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 0, 0);
      checks++;
      if (obs_mis !== 1'b1 || obs_req !== 1'b0) begin
        errors++; $display("FAIL misalign_set got mis=%b req=%b want 1 0", obs_mis, obs_req);
      end
    end
    cycle(0, 0, 1, 32'h80, 0);
    cycle(0, 0, 0, 0, 0);
    checks++;
    if (obs_mis !== 1'b0 || obs_req !== 1'b1 || obs_iaddr !== 32'h80) begin
      errors++;
      $display("FAIL misalign_clear got mis=%b req=%b addr=%h want 0 1 00000080", obs_mis, obs_req, obs_iaddr);
    end
    for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0, 0);
  endtask
`endif

  task automatic test_random();
    int n0;
    logic [31:0] t;
    bit b, c, s;
    gnt_mode = 1; rsp_pct = 70; lat_extra = 3;
    n0 = n_cons;
    for (int i = 0; i < 400; i++) begin
      b = ($urandom_range(0, 99) < 4);
      c = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 99) < 25);
      t = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'h0000_0FFF);
`ifdef FETCH_MISALIGN_EN
      t = t & 32'hFFFF_FFFC;
`endif
      cycle(b, t, c, t ^ 32'h0000_0800, s);
    end
    checks++;
    if (n_cons - n0 < 20) begin
      errors++; $display("FAIL random_progress got %0d want >=20", n_cons - n0);
    end
    gnt_mode = 0; rsp_pct = 100; lat_extra = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch();
    test_priority();
    test_gnt_low();
    test_reset_mid();
    test_wrap_align();
`ifdef FETCH_MISALIGN_EN
    test_misalign();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end
endmodule
